// File: rtl/lift_call_scheduler.sv
// Hall-call scheduler for a 4-floor lift.
// Latches hall-call buttons into a pending register. Picks the next call with a
// direction-preserving sweep and hands one request code at a time to the lift FSM.
// Then tracks arrival, clears the served lamp and times the door dwell.
// If the lift never acknowledges a request, a sticky fault is raised.
module lift_call_scheduler #(
    parameter int DWELL_CYC = 8,
    parameter int TMO_CYC   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] call_btn,
    input  logic [1:0] floor,
    input  logic       lift_busy,
    output logic [2:0] req_code,
    output logic       req_valid,
    output logic [5:0] pending,
    output logic       door_open,
    output logic       dir_up,
    output logic       fault
);

    localparam int TW = $clog2(TMO_CYC + 1);
    localparam int DW = $clog2(DWELL_CYC + 1);

    // Call bits grouped by travel direction: 1U/2U/3U and 2D/3D/4D.
    localparam logic [5:0] UP_BITS = 6'b000111;
    localparam logic [5:0] DN_BITS = 6'b111000;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ISSUE,
        WAIT_BUSY,
        WAIT_ARRIVE,
        DWELL,
        FAULT
    } state_t;

    state_t         state, state_n;
    logic [5:0]     pending_n;
    logic [5:0]     pending_clr;
    logic           dir_n;
    logic           fault_n;
    logic [1:0]     tgt_floor, tgt_floor_n;
    logic [5:0]     tgt_mask, tgt_mask_n;
    logic [TW-1:0]  tmo_cnt, tmo_n;
    logic [DW-1:0]  dwell_cnt, dwell_n;

    logic [3:0]     floor_has;
    logic [5:0]     here_calls;
    logic [5:0]     floor_press;
    logic           up_found, down_found;
    logic [1:0]     up_floor, down_floor;

    // Call bits that belong to a given floor.
    function automatic logic [5:0] floor_mask(input logic [1:0] f);
        case (f)
            2'd0:    return 6'b000001;
            2'd1:    return 6'b001010;
            2'd2:    return 6'b010100;
            default: return 6'b100000;
        endcase
    endfunction

    // Request code sent to the lift for a one-hot call bit.
    function automatic logic [2:0] code_of(input logic [5:0] m);
        case (m)
            6'b000001: return 3'b001;
            6'b000010: return 3'b010;
            6'b000100: return 3'b011;
            6'b001000: return 3'b110;
            6'b010000: return 3'b111;
            6'b100000: return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

    // At the target floor, prefer the call whose direction matches the sweep
    // when both an up and a down call are waiting there.
    function automatic logic [5:0] pick_call(input logic [5:0] p, input logic [1:0] tf,
                                             input logic d);
        logic [5:0] at_floor;
        at_floor = p & floor_mask(tf);
        if (|(at_floor & UP_BITS) && |(at_floor & DN_BITS))
            return at_floor & (d ? UP_BITS : DN_BITS);
        return at_floor;
    endfunction

    // Per-floor occupancy and nearest pending floor above and below the lift.
    always_comb begin
        floor_has   = {pending[5], pending[2] | pending[4], pending[1] | pending[3], pending[0]};
        here_calls  = pending & floor_mask(floor);
        floor_press = call_btn & floor_mask(floor);
        up_found    = 1'b0;
        up_floor    = 2'd0;
        down_found  = 1'b0;
        down_floor  = 2'd0;
        for (int f = 3; f >= 0; f--) begin
            if (f > int'(floor) && floor_has[f]) begin
                up_found = 1'b1;
                up_floor = 2'(f);
            end
        end
        for (int f = 0; f <= 3; f++) begin
            if (f < int'(floor) && floor_has[f]) begin
                down_found = 1'b1;
                down_floor = 2'(f);
            end
        end
    end

    // Next-state, scheduling decisions and counter updates.
    always_comb begin
        state_n     = state;
        pending_clr = 6'b0;
        dir_n       = dir_up;
        fault_n     = fault;
        tgt_floor_n = tgt_floor;
        tgt_mask_n  = tgt_mask;
        tmo_n       = tmo_cnt;
        dwell_n     = dwell_cnt;
        case (state)
            IDLE: begin
                if (pending != 6'b0)
                    state_n = SELECT;
            end
            SELECT: begin
                if (here_calls != 6'b0) begin
                    pending_clr = here_calls;
                    dwell_n     = '0;
                    state_n     = DWELL;
                end else if (dir_up ? up_found : down_found) begin
                    tgt_floor_n = dir_up ? up_floor : down_floor;
                    tgt_mask_n  = pick_call(pending, tgt_floor_n, dir_up);
                    state_n     = ISSUE;
                end else if (dir_up ? down_found : up_found) begin
                    dir_n       = ~dir_up;
                    tgt_floor_n = dir_up ? down_floor : up_floor;
                    tgt_mask_n  = pick_call(pending, tgt_floor_n, ~dir_up);
                    state_n     = ISSUE;
                end else begin
                    state_n = IDLE;
                end
            end
            ISSUE: begin
                tmo_n   = '0;
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (lift_busy) begin
                    state_n = WAIT_ARRIVE;
                end else if (tmo_cnt == TW'(TMO_CYC - 1)) begin
                    fault_n = 1'b1;
                    state_n = FAULT;
                end else begin
                    tmo_n = tmo_cnt + TW'(1);
                end
            end
            WAIT_ARRIVE: begin
                if (!lift_busy) begin
                    if (floor == tgt_floor) begin
                        pending_clr = tgt_mask;
                        dwell_n     = '0;
                        state_n     = DWELL;
                    end else begin
                        state_n = SELECT;
                    end
                end
            end
            DWELL: begin
                if (floor_press != 6'b0) begin
                    pending_clr = floor_mask(floor);
                    dwell_n     = '0;
                end else if (dwell_cnt == DW'(DWELL_CYC - 1)) begin
                    state_n = ((pending | call_btn) != 6'b0) ? SELECT : IDLE;
                end else begin
                    dwell_n = dwell_cnt + DW'(1);
                end
            end
            FAULT: begin
                state_n = FAULT;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        pending_n = (pending | call_btn) & ~pending_clr;
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= 6'b0;
            dir_up    <= 1'b1;
            fault     <= 1'b0;
            tgt_floor <= 2'd0;
            tgt_mask  <= 6'b0;
            tmo_cnt   <= '0;
            dwell_cnt <= '0;
        end else begin
            state     <= state_n;
            pending   <= pending_n;
            dir_up    <= dir_n;
            fault     <= fault_n;
            tgt_floor <= tgt_floor_n;
            tgt_mask  <= tgt_mask_n;
            tmo_cnt   <= tmo_n;
            dwell_cnt <= dwell_n;
        end
    end

    // Requests exist only in ISSUE; the door is open only in DWELL.
    always_comb begin
        req_valid = (state == ISSUE);
        req_code  = req_valid ? code_of(tgt_mask) : 3'b000;
        door_open = (state == DWELL);
    end

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed testbench for lift_call_scheduler.
// Expected values are hand-computed for DWELL_CYC=8 and TMO_CYC=16.
module tb_lift_call_scheduler;

    logic       clk;
    logic       rst_n;
    logic [5:0] call_btn;
    logic [1:0] floor;
    logic       lift_busy;
    logic [2:0] req_code;
    logic       req_valid;
    logic [5:0] pending;
    logic       door_open;
    logic       dir_up;
    logic       fault;

    int vectors;
    int miscompares;

    lift_call_scheduler #(.DWELL_CYC(8), .TMO_CYC(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .call_btn  (call_btn),
        .floor     (floor),
        .lift_busy (lift_busy),
        .req_code  (req_code),
        .req_valid (req_valid),
        .pending   (pending),
        .door_open (door_open),
        .dir_up    (dir_up),
        .fault     (fault)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [5:0] btn, input logic [1:0] fl, input logic busy);
        call_btn  = btn;
        floor     = fl;
        lift_busy = busy;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Single linear sequence of directed steps.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        applyStimulus(6'h00, 2'd0, 1'b0);
        tick(2);
        checkOutput("rst_pending", 8'(pending), 8'h00);
        checkOutput("rst_valid", 8'(req_valid), 8'h00);
        checkOutput("rst_code", 8'(req_code), 8'h00);
        checkOutput("rst_door", 8'(door_open), 8'h00);
        checkOutput("rst_dir", 8'(dir_up), 8'h01);
        checkOutput("rst_fault", 8'(fault), 8'h00);
        rst_n = 1'b1;

        // 4D call from floor 1: issue, travel, arrive, dwell, idle.
        applyStimulus(6'h20, 2'd0, 1'b0);
        tick(1);
        checkOutput("s1_latch", 8'(pending), 8'h20);
        checkOutput("s1_noreq_idle", 8'(req_valid), 8'h00);
        applyStimulus(6'h00, 2'd0, 1'b0);
        tick(1);
        checkOutput("s1_noreq_sel", 8'(req_valid), 8'h00);
        tick(1);
        checkOutput("s1_issue_valid", 8'(req_valid), 8'h01);
        checkOutput("s1_issue_code", 8'(req_code), 8'h04);
        applyStimulus(6'h00, 2'd0, 1'b1);
        tick(1);
        checkOutput("s1_valid_drop", 8'(req_valid), 8'h00);
        checkOutput("s1_code_drop", 8'(req_code), 8'h00);
        tick(2);
        applyStimulus(6'h00, 2'd3, 1'b0);
        tick(1);
        checkOutput("s1_served", 8'(pending), 8'h00);
        checkOutput("s1_door_open", 8'(door_open), 8'h01);
        tick(7);
        checkOutput("s1_door_last", 8'(door_open), 8'h01);
        tick(1);
        checkOutput("s1_door_closed", 8'(door_open), 8'h00);

        // Floor 2 going up with 3U and 1U: 3U first, then reverse for 1U.
        applyStimulus(6'h05, 2'd1, 1'b0);
        tick(1);
        applyStimulus(6'h00, 2'd1, 1'b0);
        tick(2);
        checkOutput("s2_first_valid", 8'(req_valid), 8'h01);
        checkOutput("s2_first_code", 8'(req_code), 8'h03);
        applyStimulus(6'h00, 2'd1, 1'b1);
        tick(2);
        applyStimulus(6'h00, 2'd2, 1'b0);
        tick(1);
        checkOutput("s2_3u_served", 8'(pending), 8'h01);
        tick(8);
        checkOutput("s2_dwell_done", 8'(door_open), 8'h00);
        tick(1);
        checkOutput("s2_second_code", 8'(req_code), 8'h01);
        checkOutput("s2_dir_toggle", 8'(dir_up), 8'h00);
        applyStimulus(6'h00, 2'd2, 1'b1);
        tick(2);
        applyStimulus(6'h00, 2'd0, 1'b0);
        tick(1);
        checkOutput("s2_1u_served", 8'(pending), 8'h00);
        tick(8);

        // Floor 2 with 2U and 3D: 2U served on the spot, presses during dwell.
        applyStimulus(6'h12, 2'd1, 1'b0);
        tick(1);
        applyStimulus(6'h00, 2'd1, 1'b0);
        tick(2);
        checkOutput("s3_here_clear", 8'(pending), 8'h10);
        checkOutput("s3_here_door", 8'(door_open), 8'h01);
        checkOutput("s3_here_noreq", 8'(req_valid), 8'h00);
        applyStimulus(6'h20, 2'd1, 1'b0);
        tick(1);
        checkOutput("s4_4d_lamp", 8'(pending), 8'h30);
        applyStimulus(6'h02, 2'd1, 1'b0);
        tick(1);
        checkOutput("s4_2u_cleared", 8'(pending), 8'h30);
        applyStimulus(6'h00, 2'd1, 1'b0);
        tick(7);
        checkOutput("s4_restart_open", 8'(door_open), 8'h01);
        tick(1);
        checkOutput("s4_restart_end", 8'(door_open), 8'h00);
        tick(1);
        checkOutput("s3_3d_code", 8'(req_code), 8'h07);
        checkOutput("s3_dir_up", 8'(dir_up), 8'h01);

        // Lift stops short of the target: call kept and re-issued.
        applyStimulus(6'h00, 2'd1, 1'b1);
        tick(2);
        applyStimulus(6'h00, 2'd0, 1'b0);
        tick(1);
        checkOutput("s6_kept", 8'(pending), 8'h30);
        checkOutput("s6_sel_noreq", 8'(req_valid), 8'h00);
        tick(1);
        checkOutput("s6_reissue_valid", 8'(req_valid), 8'h01);
        checkOutput("s6_reissue_code", 8'(req_code), 8'h07);

        // Lift never goes busy: timeout fault, then reset recovers.
        tick(16);
        checkOutput("s5_fault_early", 8'(fault), 8'h00);
        tick(1);
        checkOutput("s5_fault_set", 8'(fault), 8'h01);
        applyStimulus(6'h02, 2'd0, 1'b0);
        tick(1);
        applyStimulus(6'h00, 2'd0, 1'b0);
        checkOutput("s5_latch_in_fault", 8'(pending), 8'h32);
        tick(4);
        checkOutput("s5_noreq", 8'(req_valid), 8'h00);
        checkOutput("s5_door_shut", 8'(door_open), 8'h00);
        checkOutput("s5_fault_sticky", 8'(fault), 8'h01);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        checkOutput("s5_rst_pending", 8'(pending), 8'h00);
        checkOutput("s5_rst_fault", 8'(fault), 8'h00);
        checkOutput("s5_rst_dir", 8'(dir_up), 8'h01);
        tick(3);
        checkOutput("s5_rst_idle", 8'(req_valid), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
